// File: rtl/div_pipe.sv
// Fully pipelined unsigned restoring divider: one N/M-bit divide accepted per clock,
// quotient/remainder/div_zero registered N cycles later with a matching rdy pulse.
module div_pipe #(
   parameter int N = 8,
   parameter int M = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic [N-1:0] dividend,
   input  logic [M-1:0] divisor,
   output logic         rdy,
   output logic [N-1:0] quotient,
   output logic [M-1:0] remainder,
   output logic         div_zero
);

   // Stages 0..N-2 live in the arrays below; stage N-1 is the output register set.
   localparam int S = N - 1;

   logic [S-1:0] vld_q;
   logic [M-1:0] rem_q  [S];
   logic [N-1:0] quo_q  [S];
   logic [N-1:0] dvd_q  [S];
   logic [M-1:0] dvs_q  [S];
   logic [S-1:0] zero_q;

   // {quotient bit, new partial remainder} for each of the N stages
   logic [M:0]   st     [N];

   function automatic logic [M:0] step(input logic [M-1:0] rem_prev,
                                       input logic         dvd_bit,
                                       input logic [M-1:0] dvs);
      logic [M:0] r;
      logic [M:0] diff;
      r    = {rem_prev, dvd_bit};
      diff = r - {1'b0, dvs};
      if (r >= {1'b0, dvs}) step = {1'b1, diff[M-1:0]};
      else                  step = {1'b0, r[M-1:0]};
   endfunction

   assign st[0] = step('0, dividend[N-1], divisor);

   for (genvar g = 1; g < N; g++) begin : g_step
      assign st[g] = step(rem_q[g-1], dvd_q[g-1][N-1-g], dvs_q[g-1]);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_q[0]  <= 1'b0;
         rem_q[0]  <= '0;
         quo_q[0]  <= '0;
         dvd_q[0]  <= '0;
         dvs_q[0]  <= '0;
         zero_q[0] <= 1'b0;
      end else begin
         vld_q[0]  <= en;
         rem_q[0]  <= st[0][M-1:0];
         quo_q[0]  <= {{(N-1){1'b0}}, st[0][M]};
         dvd_q[0]  <= dividend;
         dvs_q[0]  <= divisor;
         zero_q[0] <= (divisor == '0);
      end
   end

   for (genvar g = 1; g < S; g++) begin : g_stage
      always_ff @(posedge clk) begin
         if (rst) begin
            vld_q[g]  <= 1'b0;
            rem_q[g]  <= '0;
            quo_q[g]  <= '0;
            dvd_q[g]  <= '0;
            dvs_q[g]  <= '0;
            zero_q[g] <= 1'b0;
         end else begin
            vld_q[g]  <= vld_q[g-1];
            rem_q[g]  <= st[g][M-1:0];
            quo_q[g]  <= {quo_q[g-1][N-2:0], st[g][M]};
            dvd_q[g]  <= dvd_q[g-1];
            dvs_q[g]  <= dvs_q[g-1];
            zero_q[g] <= zero_q[g-1];
         end
      end
   end

   // Output stage loads only for valid slots so results hold across bubbles.
   always_ff @(posedge clk) begin
      if (rst) begin
         rdy       <= 1'b0;
         quotient  <= '0;
         remainder <= '0;
         div_zero  <= 1'b0;
      end else begin
         rdy <= vld_q[S-1];
         if (vld_q[S-1]) begin
            if (zero_q[S-1]) begin
               quotient  <= '1;
               remainder <= dvd_q[S-1][M-1:0];
               div_zero  <= 1'b1;
            end else begin
               quotient  <= {quo_q[S-1][N-2:0], st[N-1][M]};
               remainder <= st[N-1][M-1:0];
               div_zero  <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_div_pipe.sv
// Directed bench for div_pipe: table of hand-computed divides, streaming sweep,
// bubble pattern and mid-flight reset, with a cycle-level reference model.
module tb_div_pipe;
   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic [7:0] dividend;
   logic [3:0] divisor;
   logic       rdy;
   logic [7:0] quotient;
   logic [3:0] remainder;
   logic       div_zero;

   int checks = 0;
   int errors = 0;
   int rdy_cnt = 0;
   logic mon_on = 1'b0;

   div_pipe #(.N(8), .M(4)) dut (
      .clk(clk), .rst(rst), .en(en), .dividend(dividend), .divisor(divisor),
      .rdy(rdy), .quotient(quotient), .remainder(remainder), .div_zero(div_zero)
   );

   always #5 clk = ~clk;

   // Reference: delay line of accepted operands, arithmetic done with / and %.
   logic [6:0] m_v;
   logic [7:0] m_a [7];
   logic [3:0] m_b [7];
   logic       e_rdy, e_z;
   logic [7:0] e_q;
   logic [3:0] e_r;

   always @(posedge clk) begin
      if (rst) begin
         m_v   <= '0;
         e_rdy <= 1'b0;
         e_q   <= '0;
         e_r   <= '0;
         e_z   <= 1'b0;
      end else begin
         m_v     <= {m_v[5:0], en};
         m_a[0]  <= dividend;
         m_b[0]  <= divisor;
         for (int i = 1; i < 7; i++) begin
            m_a[i] <= m_a[i-1];
            m_b[i] <= m_b[i-1];
         end
         e_rdy <= m_v[6];
         if (m_v[6]) begin
            if (m_b[6] == 4'd0) begin
               e_q <= 8'hFF;
               e_r <= m_a[6][3:0];
               e_z <= 1'b1;
            end else begin
               e_q <= m_a[6] / {4'b0, m_b[6]};
               e_r <= 4'(m_a[6] % {4'b0, m_b[6]});
               e_z <= 1'b0;
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      if (rdy === 1'b1) rdy_cnt++;
      if (mon_on)
         chk("model", 32'({rdy, quotient, remainder, div_zero}),
             32'({e_rdy, e_q, e_r, e_z}));
   endtask

   task automatic drive(input logic e, input logic [7:0] a, input logic [3:0] b);
      en       = e;
      dividend = a;
      divisor  = b;
   endtask

   task automatic run_one(input logic [7:0] a, input logic [3:0] b,
                          input logic [7:0] eq, input logic [3:0] er, input logic ez);
      int lat;
      drive(1'b1, a, b);
      tick();
      drive(1'b0, 8'h00, 4'h0);
      lat = 1;
      while (rdy !== 1'b1 && lat < 20) begin
         tick();
         lat++;
      end
      chk("latency", 32'(lat), 32'd8);
      chk("quotient", 32'(quotient), 32'(eq));
      chk("remainder", 32'(remainder), 32'(er));
      chk("div_zero", 32'(div_zero), 32'(ez));
      tick();
      chk("rdy_single", 32'(rdy), 32'd0);
   endtask

   typedef struct {
      logic [7:0] a;
      logic [3:0] b;
      logic [7:0] q;
      logic [3:0] r;
      logic       z;
   } vec_t;

   vec_t vt[7];
   int   dl[5]  = '{1, 3, 7, 9, 15};
   int   pat[7] = '{1, 0, 0, 1, 1, 0, 1};

   initial begin
      vt[0] = '{8'd100, 4'd7,  8'd14,  4'd2, 1'b0};
      vt[1] = '{8'd255, 4'd15, 8'd17,  4'd0, 1'b0};
      vt[2] = '{8'd5,   4'd9,  8'd0,   4'd5, 1'b0};
      vt[3] = '{8'd0,   4'd3,  8'd0,   4'd0, 1'b0};
      vt[4] = '{8'd255, 4'd1,  8'd255, 4'd0, 1'b0};
      vt[5] = '{8'd200, 4'd0,  8'd255, 4'd8, 1'b1};
      vt[6] = '{8'd9,   4'd3,  8'd3,   4'd0, 1'b0};

      rst = 1'b1;
      drive(1'b1, 8'd77, 4'd5);
      repeat (3) tick();
      mon_on = 1'b1;
      chk("reset_state", 32'({rdy, quotient, remainder, div_zero}), 32'd0);
      rst = 1'b0;
      drive(1'b0, 8'h00, 4'h0);
      tick();
      chk("reset_en_dropped", 32'(rdy), 32'd0);

      for (int i = 0; i < 7; i++)
         run_one(vt[i].a, vt[i].b, vt[i].q, vt[i].r, vt[i].z);

      // Streaming sweep: continuous en, results must come back gapless and in order.
      begin
         int rc0;
         rc0 = rdy_cnt;
         for (int d = 0; d < 5; d++)
            for (int a = 0; a < 256; a++) begin
               drive(1'b1, 8'(a), 4'(dl[d]));
               tick();
            end
         drive(1'b0, 8'h00, 4'h0);
         repeat (10) tick();
         chk("sweep_count", 32'(rdy_cnt - rc0), 32'd1280);
      end

      // Bubbles: rdy must reproduce the en pattern eight cycles later.
      for (int j = 0; j < 15; j++) begin
         if (j >= 8) chk("bubble_rdy", 32'(rdy), 32'(pat[j-8]));
         if (j < 7) drive(pat[j] != 0, 8'(j * 13 + 20), 4'(j + 2));
         else       drive(1'b0, 8'h00, 4'h0);
         tick();
      end
      repeat (4) tick();

      // Reset mid-flight: five ops in flight, reset on the third edge after the stream.
      for (int k = 0; k < 5; k++) begin
         drive(1'b1, 8'(30 + k * 7), 4'd5);
         tick();
      end
      drive(1'b0, 8'h00, 4'h0);
      tick();
      tick();
      rst = 1'b1;
      drive(1'b1, 8'd99, 4'd4);
      tick();
      chk("midrst_outputs", 32'({rdy, quotient, remainder, div_zero}), 32'd0);
      rst = 1'b0;
      drive(1'b0, 8'h00, 4'h0);
      begin
         int stale;
         stale = 0;
         for (int c = 0; c < 12; c++) begin
            tick();
            if (rdy !== 1'b0) stale++;
         end
         chk("midrst_no_stale", 32'(stale), 32'd0);
      end
      run_one(8'd50, 4'd6, 8'd8, 4'd2, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
